// File: rtl/sd_enmux_pkg.sv
// Shared definitions for the N:1 serializer and its companion N-beat demux.
// beat_slice is the single definition of beat order for both ends of the link.
package sd_enmux_pkg;

  localparam int MAX_W = 256;

  typedef enum logic {
    s_empty = 1'b0,
    s_busy  = 1'b1
  } state_e;

  // Returns slice (cnt or ratio-1-cnt) of hold, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] beat_slice(
    input logic [MAX_W-1:0] hold,
    input int               cnt,
    input int               bw,
    input int               ratio,
    input bit               msb_first
  );
    int k;
    k = msb_first ? (ratio - 1 - cnt) : cnt;
    return (hold >> (k * bw)) & ((MAX_W'(1) << bw) - MAX_W'(1));
  endfunction

endpackage

// File: rtl/sd_enmux_n.sv
// Srdy/drdy N:1 serializer: registers one width-bit token and emits it as
// `ratio` narrow beats, accepting the next token on the last beat.
module sd_enmux_n
  import sd_enmux_pkg::*;
#(
  parameter int width     = 32,
  parameter int ratio     = 4,
  parameter bit msb_first = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c_srdy,
  output logic                   c_drdy,
  input  logic [width-1:0]       c_data,
  output logic                   p_srdy,
  input  logic                   p_drdy,
  output logic [width/ratio-1:0] p_data,
  output logic                   p_last
);

  localparam int bw = width / ratio;
  localparam int cw = $clog2(ratio);
  localparam logic [cw-1:0] cnt_last = cw'(ratio - 1);

  if ((width % ratio) != 0 || ratio < 2 || width > MAX_W) begin : g_bad_params
    $error("sd_enmux_n: width must be divisible by ratio, ratio >= 2, width <= MAX_W");
  end

  state_e             state_q, state_d;
  logic [cw-1:0]      cnt_q, cnt_d;
  logic [width-1:0]   hold_q, hold_d;

  assign p_srdy = (state_q == s_busy);
  assign p_last = (state_q == s_busy) && (cnt_q == cnt_last);
  assign c_drdy = (state_q == s_empty) || (p_last && p_drdy);
  assign p_data = bw'(beat_slice(MAX_W'(hold_q), int'(cnt_q), bw, ratio, msb_first));

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      s_empty: begin
        if (c_srdy) begin
          hold_d  = c_data;
          cnt_d   = '0;
          state_d = s_busy;
        end
      end
      s_busy: begin
        if (p_drdy) begin
          if (!p_last) begin
            cnt_d = cnt_q + cw'(1);
          end else if (c_srdy) begin
            hold_d = c_data;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = s_empty;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = s_empty;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q <= s_empty;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_sd_enmux_n.sv
// Scoreboard bench for sd_enmux_n: MSB-first 32/4 main instance, plus an
// LSB-first 32/4 and a legacy-order 16/2 instance.
module tb_sd_enmux_n;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // main instance: width 32, ratio 4, msb_first 1
  logic        c_srdy = 1'b0, c_drdy, p_srdy, p_drdy = 1'b1, p_last;
  logic [31:0] c_data = '0;
  logic [7:0]  p_data;
  // lsb-first instance
  logic        l_c_srdy = 1'b0, l_c_drdy, l_p_srdy, l_p_last;
  logic [31:0] l_c_data = '0;
  logic [7:0]  l_p_data;
  // ratio 2 instance
  logic        r_c_srdy = 1'b0, r_c_drdy, r_p_srdy, r_p_last;
  logic [15:0] r_c_data = '0;
  logic [7:0]  r_p_data;

  beat_t q_m[$], q_l[$], q_r[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_beats = 0;

  always #5 clk = ~clk;

  sd_enmux_n #(.width(32), .ratio(4), .msb_first(1'b1)) dut (
    .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_last(p_last));

  sd_enmux_n #(.width(32), .ratio(4), .msb_first(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .c_srdy(l_c_srdy), .c_drdy(l_c_drdy), .c_data(l_c_data),
    .p_srdy(l_p_srdy), .p_drdy(1'b1), .p_data(l_p_data), .p_last(l_p_last));

  sd_enmux_n #(.width(16), .ratio(2), .msb_first(1'b1)) dut_r2 (
    .clk(clk), .reset(reset), .c_srdy(r_c_srdy), .c_drdy(r_c_drdy), .c_data(r_c_data),
    .p_srdy(r_p_srdy), .p_drdy(1'b1), .p_data(r_p_data), .p_last(r_p_last));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard model: expected beats of one 8-bit-beat token.
  task automatic push_token(inout beat_t q[$], input logic [31:0] d, input int ratio,
                            input bit msb);
    for (int i = 0; i < ratio; i++) begin
      int k;
      beat_t b;
      k = msb ? (ratio - 1 - i) : i;
      b.data = d[k*8 +: 8];
      b.last = (i == ratio - 1);
      q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (p_srdy && p_drdy) begin
        if (q_m.size() == 0) check("m_unexpected_beat", {24'h0, p_data}, 32'hxxxx_xxxx);
        else begin
          beat_t e;
          e = q_m.pop_front();
          check("m_data", {24'h0, p_data}, {24'h0, e.data});
          check("m_last", {31'h0, p_last}, {31'h0, e.last});
          n_beats++;
        end
      end
      if (c_srdy && c_drdy) push_token(q_m, c_data, 4, 1'b1);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (l_p_srdy) begin
        if (q_l.size() == 0) check("l_unexpected_beat", {24'h0, l_p_data}, 32'hxxxx_xxxx);
        else begin
          beat_t e;
          e = q_l.pop_front();
          check("l_data", {24'h0, l_p_data}, {24'h0, e.data});
          check("l_last", {31'h0, l_p_last}, {31'h0, e.last});
        end
      end
      if (l_c_srdy && l_c_drdy) push_token(q_l, l_c_data, 4, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (r_p_srdy) begin
        if (q_r.size() == 0) check("r_unexpected_beat", {24'h0, r_p_data}, 32'hxxxx_xxxx);
        else begin
          beat_t e;
          e = q_r.pop_front();
          check("r_data", {24'h0, r_p_data}, {24'h0, e.data});
          check("r_last", {31'h0, r_p_last}, {31'h0, e.last});
        end
      end
      if (r_c_srdy && r_c_drdy) push_token(q_r, {16'h0, r_c_data}, 2, 1'b1);
    end
  end

  // Drives a token on the main instance; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] d, input bit keep);
    bit found;
    found  = 1'b0;
    c_srdy = 1'b1;
    c_data = d;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (c_drdy) found = 1'b1;
    end
    if (!found) check("accept_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    if (!keep) c_srdy = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && (q_m.size() != 0 || p_srdy); i++) @(posedge clk);
    #1;
    check(tag, 32'(q_m.size()), 32'h0);
  endtask

  initial begin
    int base;
    bit found;

    #12;
    check("rst_p_srdy", {31'h0, p_srdy}, 32'h0);
    check("rst_p_last", {31'h0, p_last}, 32'h0);
    check("rst_p_data", {24'h0, p_data}, 32'h0);
    check("rst_c_drdy", {31'h0, c_drdy}, 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;

    // single token, exact latency and idle afterwards
    send(32'hA1B2C3D4, 1'b0);
    check("single_first_valid", {31'h0, p_srdy}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check("single_idle_after", {31'h0, p_srdy}, 32'h0);
    check("single_drained", 32'(q_m.size()), 32'h0);

    // back-to-back with no bubble
    base = n_beats;
    send(32'h11223344, 1'b1);
    c_data = 32'h55667788;
    found  = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (c_drdy) begin
        found = 1'b1;
        check("b2b_drdy_beat", {24'h0, p_data}, 32'h44);
      end
    end
    check("b2b_drdy_seen", {31'h0, found}, 32'h1);
    @(posedge clk);
    #1 c_srdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_no_gap", 32'(n_beats - base), 32'd8);
    drain("b2b_drained");

    // backpressure on B2
    send(32'hA1B2C3D4, 1'b0);
    @(posedge clk);
    #1 p_drdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_data", {24'h0, p_data}, 32'hB2);
      check("bp_c_drdy", {31'h0, c_drdy}, 32'h0);
      check("bp_p_last", {31'h0, p_last}, 32'h0);
      @(posedge clk);
      #1;
    end
    p_drdy = 1'b1;
    drain("bp_drained");

    // upstream changes data right after acceptance
    send(32'hA1B2C3D4, 1'b0);
    c_data = 32'hFFFFFFFF;
    drain("src_indep_drained");

    // mid-token reset after B2 is accepted
    send(32'hA1B2C3D4, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_p_srdy", {31'h0, p_srdy}, 32'h0);
    check("mid_rst_p_last", {31'h0, p_last}, 32'h0);
    q_m.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    send(32'h0A0B0C0D, 1'b0);
    drain("post_rst_drained");

    // lsb-first and legacy 2:1 order
    l_c_data = 32'hA1B2C3D4;
    l_c_srdy = 1'b1;
    r_c_data = 16'hBEEF;
    r_c_srdy = 1'b1;
    @(posedge clk);
    #1;
    l_c_srdy = 1'b0;
    r_c_srdy = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("lsb_drained", 32'(q_l.size()), 32'h0);
    check("r2_drained", 32'(q_r.size()), 32'h0);
    check("lsb_idle", {31'h0, l_p_srdy}, 32'h0);
    check("r2_idle", {31'h0, r_p_srdy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
